// File: rtl/jtag_tap_slave.sv
// jtag_tap_slave: clk-oversampled IEEE 1149.1 TAP with IDCODE, BYPASS and a USER DR tied to a local fifo.
// Define JTAG_TDO_OE_EN to add a tdo_oe output that gates tdo outside the shift states.
module jtag_tap_slave #(
    parameter int unsigned         IR_WIDTH     = 10,
    parameter int unsigned         DR_WIDTH     = 8,
    parameter logic [31:0]         IDCODE_VAL   = 32'h1234_5677,
    parameter logic [IR_WIDTH-1:0] INSTR_IDCODE = 'h001,
    parameter logic [IR_WIDTH-1:0] INSTR_USER   = 'h002
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                tck,
    input  logic                tms,
    input  logic                tdi,
    output logic                tdo,
`ifdef JTAG_TDO_OE_EN
    output logic                tdo_oe,
`endif
    input  logic [DR_WIDTH-1:0] dr_rdata,
    output logic                dr_rd,
    output logic [DR_WIDTH-1:0] dr_wdata,
    output logic                dr_wr,
    output logic [IR_WIDTH-1:0] ir_value
);

    typedef enum logic [3:0] {
        TLR   = 4'hF, RTI   = 4'hC, SELDR = 4'h7, CAPDR = 4'h6,
        SHDR  = 4'h2, EX1DR = 4'h1, PDR   = 4'h3, EX2DR = 4'h0,
        UPDR  = 4'h5, SELIR = 4'h4, CAPIR = 4'hE, SHIR  = 4'hA,
        EX1IR = 4'h9, PIR   = 4'hB, EX2IR = 4'h8, UPIR  = 4'hD
    } tap_state_e;

    tap_state_e state_q, state_d;

    logic tck_s1_q, tck_s2_q, tck_s3_q;
    logic tms_s1_q, tms_s2_q;
    logic tdi_s1_q, tdi_s2_q;
    logic tck_rise, tck_fall;

    logic [IR_WIDTH-1:0] ir_shift_q, ir_shift_d;
    logic [IR_WIDTH-1:0] ir_value_q, ir_value_d;
    logic [31:0]         dr32_q, dr32_d;
    logic [DR_WIDTH-1:0] usr_q, usr_d;
    logic                byp_q, byp_d;
    logic [DR_WIDTH-1:0] dr_wdata_q, dr_wdata_d;
    logic                dr_rd_q, dr_rd_d;
    logic                dr_wr_q, dr_wr_d;
    logic                tdo_q, tdo_d;
    logic                sel_idcode, sel_user;

    // Pin synchronizers; the third tck flop turns the level into single-clk edge strobes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tck_s1_q <= 1'b0;
            tck_s2_q <= 1'b0;
            tck_s3_q <= 1'b0;
            tms_s1_q <= 1'b0;
            tms_s2_q <= 1'b0;
            tdi_s1_q <= 1'b0;
            tdi_s2_q <= 1'b0;
        end else begin
            tck_s1_q <= tck;
            tck_s2_q <= tck_s1_q;
            tck_s3_q <= tck_s2_q;
            tms_s1_q <= tms;
            tms_s2_q <= tms_s1_q;
            tdi_s1_q <= tdi;
            tdi_s2_q <= tdi_s1_q;
        end
    end

    assign tck_rise = tck_s2_q & ~tck_s3_q;
    assign tck_fall = ~tck_s2_q & tck_s3_q;

    // Any IR code other than IDCODE or USER selects BYPASS.
    assign sel_idcode = (ir_value_q == INSTR_IDCODE);
    assign sel_user   = (ir_value_q == INSTR_USER);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= TLR;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tck_rise) begin
            unique case (state_q)
                TLR:     state_d = tms_s2_q ? TLR   : RTI;
                RTI:     state_d = tms_s2_q ? SELDR : RTI;
                SELDR:   state_d = tms_s2_q ? SELIR : CAPDR;
                CAPDR:   state_d = tms_s2_q ? EX1DR : SHDR;
                SHDR:    state_d = tms_s2_q ? EX1DR : SHDR;
                EX1DR:   state_d = tms_s2_q ? UPDR  : PDR;
                PDR:     state_d = tms_s2_q ? EX2DR : PDR;
                EX2DR:   state_d = tms_s2_q ? UPDR  : SHDR;
                UPDR:    state_d = tms_s2_q ? SELDR : RTI;
                SELIR:   state_d = tms_s2_q ? TLR   : CAPIR;
                CAPIR:   state_d = tms_s2_q ? EX1IR : SHIR;
                SHIR:    state_d = tms_s2_q ? EX1IR : SHIR;
                EX1IR:   state_d = tms_s2_q ? UPIR  : PIR;
                PIR:     state_d = tms_s2_q ? EX2IR : PIR;
                EX2IR:   state_d = tms_s2_q ? UPIR  : SHIR;
                UPIR:    state_d = tms_s2_q ? SELDR : RTI;
                default: state_d = TLR;
            endcase
        end
    end

    always_comb begin
        ir_shift_d = ir_shift_q;
        ir_value_d = ir_value_q;
        dr32_d     = dr32_q;
        usr_d      = usr_q;
        byp_d      = byp_q;
        dr_wdata_d = dr_wdata_q;
        dr_rd_d    = 1'b0;
        dr_wr_d    = 1'b0;
        tdo_d      = tdo_q;
        if (tck_rise) begin
            unique case (state_q)
                CAPIR: ir_shift_d = {{(IR_WIDTH-2){1'b0}}, 2'b01};
                SHIR:  ir_shift_d = {tdi_s2_q, ir_shift_q[IR_WIDTH-1:1]};
                CAPDR: begin
                    if (sel_idcode) begin
                        dr32_d = IDCODE_VAL;
                    end else if (sel_user) begin
                        usr_d   = dr_rdata;
                        dr_rd_d = 1'b1;
                    end else begin
                        byp_d = 1'b0;
                    end
                end
                SHDR: begin
                    if (sel_idcode) begin
                        dr32_d = {tdi_s2_q, dr32_q[31:1]};
                    end else if (sel_user) begin
                        usr_d = {tdi_s2_q, usr_q[DR_WIDTH-1:1]};
                    end else begin
                        byp_d = tdi_s2_q;
                    end
                end
                default: ;
            endcase
            if (state_d == TLR) begin
                ir_value_d = INSTR_IDCODE;
            end
        end
        // Updates and tdo move on the falling edge so the master samples stable data on its rise.
        if (tck_fall) begin
            unique case (state_q)
                UPIR: ir_value_d = ir_shift_q;
                UPDR: begin
                    if (sel_user) begin
                        dr_wdata_d = usr_q;
                        dr_wr_d    = 1'b1;
                    end
                end
                SHIR: tdo_d = ir_shift_q[0];
                SHDR: tdo_d = sel_idcode ? dr32_q[0] : (sel_user ? usr_q[0] : byp_q);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ir_shift_q <= '0;
            ir_value_q <= INSTR_IDCODE;
            dr32_q     <= '0;
            usr_q      <= '0;
            byp_q      <= 1'b0;
            dr_wdata_q <= '0;
            dr_rd_q    <= 1'b0;
            dr_wr_q    <= 1'b0;
            tdo_q      <= 1'b0;
        end else begin
            ir_shift_q <= ir_shift_d;
            ir_value_q <= ir_value_d;
            dr32_q     <= dr32_d;
            usr_q      <= usr_d;
            byp_q      <= byp_d;
            dr_wdata_q <= dr_wdata_d;
            dr_rd_q    <= dr_rd_d;
            dr_wr_q    <= dr_wr_d;
            tdo_q      <= tdo_d;
        end
    end

`ifdef JTAG_TDO_OE_EN
    logic tdo_oe_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tdo_oe_q <= 1'b0;
        end else if (tck_fall) begin
            tdo_oe_q <= (state_q == SHIR) || (state_q == SHDR);
        end
    end

    assign tdo_oe = tdo_oe_q;
    assign tdo    = tdo_q & tdo_oe_q;
`else
    assign tdo = tdo_q;
`endif

    assign dr_rd    = dr_rd_q;
    assign dr_wr    = dr_wr_q;
    assign dr_wdata = dr_wdata_q;
    assign ir_value = ir_value_q;

endmodule

// File: tb/tb_jtag_tap_slave.sv
// Scoreboard bench for jtag_tap_slave: the driver pushes expected tdo bits, fifo pulses and
// status snapshots into queues; one monitor process pops and compares them against the DUT.
module tb_jtag_tap_slave;
    localparam int IRW = 10;
    localparam int DRW = 8;
    localparam logic [31:0] IDC = 32'h1234_5677;

    logic clk = 1'b0;
    logic rst, tck, tms, tdi, tdo;
    logic [DRW-1:0] dr_rdata, dr_wdata;
    logic dr_rd, dr_wr;
    logic [IRW-1:0] ir_value;
`ifdef JTAG_TDO_OE_EN
    logic tdo_oe;
`endif

    always #5 clk = ~clk;

    jtag_tap_slave dut (
        .clk(clk), .rst(rst), .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo),
`ifdef JTAG_TDO_OE_EN
        .tdo_oe(tdo_oe),
`endif
        .dr_rdata(dr_rdata), .dr_rd(dr_rd), .dr_wdata(dr_wdata), .dr_wr(dr_wr),
        .ir_value(ir_value)
    );

    typedef struct packed {
        logic [IRW-1:0] ir;
        logic           chk_tdo;
        logic           tdo;
    } stat_t;

    logic           tdo_exp_q[$];
    logic [DRW-1:0] wr_exp_q[$];
    int             rd_exp_q[$];
    stat_t          stat_q[$];
    int vecs = 0;
    int errs = 0;
    int drain_req = 0;
    logic tdo_chk = 1'b0;
    logic [IRW-1:0] m_ir;

    // Reference model: register length and captured value for the current instruction.
    function automatic int dr_len(input logic [IRW-1:0] ir);
        if (ir == 10'h001) return 32;
        if (ir == 10'h002) return DRW;
        return 1;
    endfunction

    function automatic logic [63:0] cap_val(input logic [IRW-1:0] ir, input logic [DRW-1:0] rd);
        if (ir == 10'h001) return {32'd0, IDC};
        if (ir == 10'h002) return {56'd0, rd};
        return 64'd0;
    endfunction

    task automatic tcyc(input logic m, input logic d, input logic chk, input logic e);
        if (chk) tdo_exp_q.push_back(e);
        tms = m; tdi = d; tdo_chk = chk;
        repeat (5) @(posedge clk); #2; tck = 1'b1;
        repeat (5) @(posedge clk); #2; tck = 1'b0;
    endtask

    task automatic goto_tlr();
        repeat (5) tcyc(1'b1, 1'b0, 1'b0, 1'b0);
        m_ir = 10'h001;
    endtask

    task automatic expect_stat(input logic chk_t, input logic t);
        stat_t s;
        s.ir = m_ir; s.chk_tdo = chk_t; s.tdo = t;
        stat_q.push_back(s);
    endtask

    task automatic drain();
        repeat (8) @(posedge clk); #2;
        drain_req++;
        repeat (3) @(posedge clk); #2;
    endtask

    // Full scan from RTI back to RTI. The serial output stream is the captured value followed by
    // the tdi stream delayed by the register length; the register ends holding the next bits of it.
    task automatic scan(input logic is_ir, input int n, input logic [63:0] din);
        logic [63:0] st;
        int len;
        if (is_ir) begin
            st = 64'd1 | (din << IRW);
        end else begin
            len = dr_len(m_ir);
            st = cap_val(m_ir, dr_rdata) | (din << len);
            if (m_ir == 10'h002) rd_exp_q.push_back(1);
        end
        tcyc(1'b1, 1'b0, 1'b0, 1'b0);
        if (is_ir) tcyc(1'b1, 1'b0, 1'b0, 1'b0);
        tcyc(1'b0, 1'b0, 1'b0, 1'b0);
        tcyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < n; i++) tcyc(i == n - 1, din[i], 1'b1, st[i]);
        if (!is_ir && m_ir == 10'h002) wr_exp_q.push_back(st[n +: DRW]);
        tcyc(1'b1, 1'b0, 1'b0, 1'b0);
        tcyc(1'b0, 1'b0, 1'b0, 1'b0);
        if (is_ir) m_ir = st[n +: IRW];
    endtask

    // USER scan split by a long pause: 4 bits, Pause-DR, Exit2 back to Shift, 4 more bits.
    task automatic user_pause_scan(input logic [DRW-1:0] din);
        logic [63:0] st;
        st = {56'd0, dr_rdata} | ({56'd0, din} << DRW);
        rd_exp_q.push_back(1);
        wr_exp_q.push_back(din);
        tcyc(1'b1, 1'b0, 1'b0, 1'b0);
        tcyc(1'b0, 1'b0, 1'b0, 1'b0);
        tcyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) tcyc(i == 3, din[i], 1'b1, st[i]);
        repeat (21) tcyc(1'b0, 1'b0, 1'b0, 1'b0);
        tcyc(1'b1, 1'b0, 1'b0, 1'b0);
        tcyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 4; i < 8; i++) tcyc(i == 7, din[i], 1'b1, st[i]);
        tcyc(1'b1, 1'b0, 1'b0, 1'b0);
        tcyc(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        logic tck_prev;
        logic e;
        stat_t s;
        logic [DRW-1:0] w;
        int drain_seen;
        tck_prev = 1'b0;
        drain_seen = 0;
        forever begin
            @(negedge clk);
            if (tck === 1'b1 && tck_prev === 1'b0 && tdo_chk) begin
                vecs++;
                if (tdo_exp_q.size() == 0) begin
                    errs++; $display("FAIL tdo_extra: got %b, required no sample", tdo);
                end else begin
                    e = tdo_exp_q.pop_front();
                    if (tdo !== e) begin
                        errs++; $display("FAIL tdo_bit: got %b, required %b at %0t", tdo, e, $time);
                    end
                end
            end
            tck_prev = tck;
            if (dr_rd === 1'b1) begin
                vecs++;
                if (rd_exp_q.size() == 0) begin
                    errs++; $display("FAIL dr_rd_pulse: got 1, required 0 at %0t", $time);
                end else begin
                    void'(rd_exp_q.pop_front());
                end
            end
            if (dr_wr === 1'b1) begin
                vecs++;
                if (wr_exp_q.size() == 0) begin
                    errs++; $display("FAIL dr_wr_pulse: got 1, required 0 at %0t", $time);
                end else begin
                    w = wr_exp_q.pop_front();
                    if (dr_wdata !== w) begin
                        errs++; $display("FAIL dr_wdata: got %h, required %h", dr_wdata, w);
                    end
                end
            end
            if (dr_rd === 1'b1 && dr_wr === 1'b1) begin
                vecs++; errs++; $display("FAIL rd_wr_overlap: got both 1, required exclusive");
            end
            if (stat_q.size() != 0) begin
                s = stat_q.pop_front();
                vecs++;
                if (ir_value !== s.ir) begin
                    errs++; $display("FAIL ir_value: got %h, required %h", ir_value, s.ir);
                end
                if (s.chk_tdo) begin
                    vecs++;
                    if (tdo !== s.tdo) begin
                        errs++; $display("FAIL tdo_level: got %b, required %b", tdo, s.tdo);
                    end
                end
`ifdef JTAG_TDO_OE_EN
                vecs++;
                if (tdo_oe !== 1'b0) begin
                    errs++; $display("FAIL tdo_oe: got %b, required 0", tdo_oe);
                end
`endif
            end
            if (drain_req != drain_seen) begin
                drain_seen = drain_req;
                vecs++;
                if (tdo_exp_q.size() != 0) begin
                    errs++; $display("FAIL tdo_missing: %0d bits left, required 0", tdo_exp_q.size());
                end
                vecs++;
                if (rd_exp_q.size() != 0) begin
                    errs++; $display("FAIL dr_rd_missing: %0d left, required 0", rd_exp_q.size());
                end
                vecs++;
                if (wr_exp_q.size() != 0) begin
                    errs++; $display("FAIL dr_wr_missing: %0d left, required 0", wr_exp_q.size());
                end
            end
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [IRW-1:0] ir_pick;
        rst = 1'b1; tck = 1'b0; tms = 1'b0; tdi = 1'b0; dr_rdata = '0;
        m_ir = 10'h001;
        repeat (3) @(posedge clk); #2;
        expect_stat(1'b1, 1'b0);
        repeat (3) @(posedge clk); #2;
        rst = 1'b0;

        // IDCODE straight after reset.
        tcyc(1'b0, 1'b0, 1'b0, 1'b0);
        scan(1'b0, 32, 64'd0);
        drain();

        // Random walks always end in TLR after five tms=1 rises.
        for (int k = 0; k < 3; k++) begin
            scan(1'b1, IRW, 64'h3FF);
            repeat (12) tcyc(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0);
            goto_tlr();
            repeat (6) @(posedge clk); #2;
            expect_stat(1'b0, 1'b0);
            tcyc(1'b0, 1'b0, 1'b0, 1'b0);
            scan(1'b0, 32, {$urandom, $urandom});
            scan(1'b1, IRW, 64'd0);
        end
        drain();

        // BYPASS delays tdi by one bit.
        scan(1'b1, IRW, 64'h3FF);
        scan(1'b0, 9, 64'h0A5);
        drain();

        // USER capture and update.
        scan(1'b1, IRW, 64'h002);
        dr_rdata = 8'h96;
        scan(1'b0, 8, 64'h3C);
        drain();

        // USER scan interrupted by Pause-DR.
        dr_rdata = 8'($urandom);
        user_pause_scan(8'($urandom));
        drain();

        // Randomised instructions, lengths and data.
        for (int k = 0; k < 12; k++) begin
            case ($urandom_range(0, 3))
                0: ir_pick = 10'h001;
                1: ir_pick = 10'h002;
                2: ir_pick = 10'h3FF;
                default: ir_pick = 10'($urandom);
            endcase
            scan(1'b1, IRW, {54'd0, ir_pick});
            dr_rdata = 8'($urandom);
            scan(1'b0, int'($urandom_range(1, 40)), {$urandom, $urandom});
        end
        drain();

        // Reset in the middle of a USER shift discards the scan.
        scan(1'b1, IRW, 64'h002);
        dr_rdata = 8'($urandom);
        rd_exp_q.push_back(1);
        tcyc(1'b1, 1'b0, 1'b0, 1'b0);
        tcyc(1'b0, 1'b0, 1'b0, 1'b0);
        tcyc(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tcyc(1'b0, 1'($urandom_range(0, 1)), 1'b1, dr_rdata[i]);
        #3;
        rst = 1'b1;
        m_ir = 10'h001;
        repeat (2) @(posedge clk); #2;
        expect_stat(1'b1, 1'b0);
        repeat (4) @(posedge clk); #2;
        rst = 1'b0;
        drain();
        tcyc(1'b0, 1'b0, 1'b0, 1'b0);
        scan(1'b0, 32, {$urandom, $urandom});
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
